// File: rtl/fp_result_collector.sv
// Result-side collector for the fp add/sub pipeline: a small FIFO of results with their
// exception flags, drained over valid/ready, plus a sticky exception/overrun register.
module fp_result_collector #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  result_in,
  input  logic                         overflow_in,
  input  logic                         underflow_in,
  input  logic                         inexact_in,
  input  logic                         invalid_operation_in,
  input  logic                         valid_data_in,
  output logic [31:0]                  out,
  output logic [3:0]                   out_flags,
  output logic                         valid_data_out,
  input  logic                         ready_in,
  output logic [4:0]                   sticky_flags,
  input  logic                         clear_flags,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fp_result_collector: DEPTH must be a power of two and at least 2");
  end

  logic [35:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    sticky_q, sticky_d;

  logic       full;
  logic       push;
  logic       pop;
  logic       drop;
  logic [3:0] in_flags;
  logic [4:0] raised;

  assign in_flags = {invalid_operation_in, overflow_in, underflow_in, inexact_in};

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    pop      = (count_q != '0) && ready_in;
    // A full FIFO still accepts when the head leaves on the same edge.
    push     = valid_data_in && (!full || pop);
    drop     = valid_data_in && full && !pop;
    raised   = {drop, valid_data_in ? in_flags : 4'b0000};

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Events raised this cycle survive a simultaneous clear.
    sticky_d = clear_flags ? raised : (sticky_q | raised);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= {in_flags, result_in};
    end
  end

  assign out            = mem_q[rd_ptr_q][31:0];
  assign out_flags      = mem_q[rd_ptr_q][35:32];
  assign valid_data_out = (count_q != '0);
  assign sticky_flags   = sticky_q;
  assign count          = count_q;

endmodule
